// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the multi-cycle multiply/divide unit and the
// HI/LO register pair. Accepts one md operation per start pulse, counts out
// the fixed latency, then commits the shadow result to HI/LO.
// Optional divider: define MULDIV_DIV_EN to support div/divu; otherwise they
// decode as no-ops.
module muldiv_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        md_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [4:0] MULT_LAST = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LAST  = 5'(DIV_CYCLES - 1);

    state_t      state, next_state;
    logic [4:0]  cnt, next_cnt;
    logic        commit;
    logic        accept;
    logic        is_mul, is_div, is_mthi, is_mtlo;
    logic [63:0] product;
    logic [31:0] res_hi, res_lo;
    logic        res_div0;

    // Operation decode; div/divu only decode when the divider is built
    always_comb begin
        is_mul  = (md_op == 3'b001) || (md_op == 3'b010);
        is_mthi = (md_op == 3'b101);
        is_mtlo = (md_op == 3'b110);
`ifdef MULDIV_DIV_EN
        is_div  = (md_op == 3'b011) || (md_op == 3'b100);
`else
        is_div  = 1'b0;
`endif
    end

    // 32x32->64 multiplier; operands extended to 64 bits per signedness
    always_comb begin
        if (md_op == 3'b001) begin
            product = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
        end else begin
            product = {32'd0, op_a} * {32'd0, op_b};
        end
    end

`ifdef MULDIV_DIV_EN
    logic        div_signed, a_neg, b_neg, div_zero;
    logic [31:0] mag_a, mag_b, divisor, uq, ur, quo, rem;

    // Divider on magnitudes so the most-negative dividend needs no special case;
    // signs reapplied afterwards (quotient toward zero, remainder follows dividend)
    always_comb begin
        div_signed = (md_op == 3'b011);
        a_neg      = div_signed && op_a[31];
        b_neg      = div_signed && op_b[31];
        mag_a      = a_neg ? (32'd0 - op_a) : op_a;
        mag_b      = b_neg ? (32'd0 - op_b) : op_b;
        div_zero   = (op_b == '0);
        divisor    = div_zero ? 32'd1 : mag_b;
        uq         = mag_a / divisor;
        ur         = mag_a % divisor;
        quo        = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem        = a_neg ? (32'd0 - ur) : ur;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state, latency counter and commit strobe
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        commit     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (is_mul) begin
                        next_state = MUL;
                        next_cnt   = MULT_LAST;
                    end else if (is_div) begin
                        next_state = DIV;
                        next_cnt   = DIV_LAST;
                    end
                end
            end
            MUL, DIV: begin
                if (cnt == '0) begin
                    next_state = IDLE;
                    commit     = 1'b1;
                end else begin
                    next_cnt = cnt - 5'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shadow result capture, mthi/mtlo writes and HI/LO commit
    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            res_hi   <= '0;
            res_lo   <= '0;
            res_div0 <= 1'b0;
        end else if (accept) begin
            if (is_mul) begin
                res_hi   <= product[63:32];
                res_lo   <= product[31:0];
                res_div0 <= 1'b0;
            end
`ifdef MULDIV_DIV_EN
            if (is_div) begin
                res_hi   <= rem;
                res_lo   <= quo;
                res_div0 <= div_zero;
            end
`endif
            if (is_mthi) begin
                hi <= op_a;
            end
            if (is_mtlo) begin
                lo <= op_a;
            end
        end else if (commit && !res_div0) begin
            hi <= res_hi;
            lo <= res_lo;
        end
    end

    // Busy and hazard stall request
    always_comb begin
        busy     = (state != IDLE);
        stall_md = md_D && (busy || (start && (is_mul || is_div)));
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed steps from the test plan,
// then randomized traffic against a remaining-cycles reference model.
module tb_muldiv_ctrl;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, md_D;
    logic [2:0]  md_op;
    logic [31:0] op_a, op_b;
    logic        busy, stall_md;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int busy_seen = 0;
    int stall_seen = 0;

    // Reference model state
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
    bit          m_valid = 1'b0;
    logic [31:0] saved;

    muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .op_a(op_a), .op_b(op_b), .md_D(md_D), .busy(busy),
        .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        if (op == 3'b001) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = a;
        ub = b;
        return ua * ub;
    endfunction

    // Returns {remainder, quotient}; divisor must be nonzero
    function automatic logic [63:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (op == 3'b011) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic bit is_div_op(input logic [2:0] op);
`ifdef MULDIV_DIV_EN
        return (op == 3'b011) || (op == 3'b100);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        if (r) begin
            m_left = 0;
            m_hi = '0;
            m_lo = '0;
            m_valid = 1'b0;
        end else if (m_left == 0) begin
            if (s) begin
                if (op == 3'b001 || op == 3'b010) begin
                    {m_rhi, m_rlo} = ref_mul(op, a, b);
                    m_valid = 1'b1;
                    m_left = MC;
                end else if (is_div_op(op)) begin
                    m_valid = (b != 0);
                    if (m_valid) {m_rhi, m_rlo} = ref_div(op, a, b);
                    m_left = DC;
                end else if (op == 3'b101) begin
                    m_hi = a;
                end else if (op == 3'b110) begin
                    m_lo = a;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0 && m_valid) begin
                m_hi = m_rhi;
                m_lo = m_rlo;
            end
        end
    endtask

    // One clock: drive inputs, check at negedge, advance model at posedge
    task automatic cyc(input logic r, input logic s, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic d);
        bit exp_stall;
        reset = r; start = s; md_op = op; op_a = a; op_b = b; md_D = d;
        @(negedge clk);
        if (chk_en) begin
            exp_stall = d && ((m_left != 0) ||
                        (s && (op == 3'b001 || op == 3'b010 || is_div_op(op))));
            chk("busy", 64'(busy), 64'(m_left != 0));
            chk("stall_md", 64'(stall_md), 64'(exp_stall));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
        if (busy === 1'b1) busy_seen++;
        if (stall_md === 1'b1) stall_seen++;
        @(posedge clk);
        model_edge(r, s, op, a, b);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'b000, '0, '0, 1'b0);
    endtask

    initial begin
        logic        r, s, d;
        logic [2:0]  op;
        logic [31:0] a, b;

        // Reset
        cyc(1'b1, 1'b0, 3'b000, '0, '0, 1'b0);
        chk_en = 1'b1;
        cyc(1'b1, 1'b1, 3'b001, 32'd5, 32'd5, 1'b0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);

        // mult 3 * -2
        busy_seen = 0;
        cyc(1'b0, 1'b1, 3'b001, 32'd3, 32'hFFFF_FFFE, 1'b0);
        idle(MC + 1);
        chk("mult_busy_cycles", 64'(busy_seen), 64'(MC));
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);

        // multu 0xFFFFFFFF * 2
        cyc(1'b0, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(MC + 1);
        chk("multu_hi", 64'(hi), 64'h1);
        chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

        // div -7 / 2
        busy_seen = 0;
        cyc(1'b0, 1'b1, 3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DC + 1);
`ifdef MULDIV_DIV_EN
        chk("div_busy_cycles", 64'(busy_seen), 64'(DC));
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
`else
        chk("div_off_busy", 64'(busy_seen), 64'd0);
        chk("div_off_hi", 64'(hi), 64'h1);
        chk("div_off_lo", 64'(lo), 64'hFFFF_FFFE);
`endif

        // divu 7 / 0: HI/LO unchanged
        busy_seen = 0;
        saved = hi;
        cyc(1'b0, 1'b1, 3'b100, 32'd7, 32'd0, 1'b0);
        idle(DC + 1);
`ifdef MULDIV_DIV_EN
        chk("divz_busy_cycles", 64'(busy_seen), 64'(DC));
        chk("divz_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("divz_lo", 64'(lo), 64'hFFFF_FFFD);
`else
        chk("divz_off_busy", 64'(busy_seen), 64'd0);
        chk("divz_off_hi", 64'(hi), 64'(saved));
`endif

        // Signed overflow: 0x80000000 / -1
        cyc(1'b0, 1'b1, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DC + 1);
`ifdef MULDIV_DIV_EN
        chk("divov_lo", 64'(lo), 64'h8000_0000);
        chk("divov_hi", 64'(hi), 64'h0);
`endif

        // Stall with md_D held high, then with md_D low
        cyc(1'b0, 1'b1, 3'b001, 32'd7, 32'd9, 1'b1);
        for (int i = 0; i < int'(MC) + 1; i++) cyc(1'b0, 1'b0, 3'b000, '0, '0, 1'b1);
        stall_seen = 0;
        cyc(1'b0, 1'b1, 3'b001, 32'd7, 32'd9, 1'b0);
        idle(MC + 1);
        chk("stall_mdD0", 64'(stall_seen), 64'd0);

        // mthi while idle; mtlo while busy is ignored
        cyc(1'b0, 1'b1, 3'b101, 32'h0000_1234, '0, 1'b1);
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_busy", 64'(busy), 64'd0);
        saved = lo;
        cyc(1'b0, 1'b1, 3'b010, 32'd10, 32'd10, 1'b0);
        cyc(1'b0, 1'b1, 3'b110, 32'hDEAD_BEEF, '0, 1'b0);
        chk("mtlo_busy_lo", 64'(lo), 64'(saved));
        idle(MC);
        chk("mtlo_busy_commit", 64'(lo), 64'd100);

        // Reset during third busy cycle of a div
        cyc(1'b0, 1'b1, 3'b011, 32'd100, 32'd3, 1'b0);
        idle(2);
        cyc(1'b1, 1'b0, 3'b000, '0, '0, 1'b0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_hi", 64'(hi), 64'd0);
        chk("rstmid_lo", 64'(lo), 64'd0);
        idle(DC + 2);
        chk("rstmid_nocommit_hi", 64'(hi), 64'd0);
        chk("rstmid_nocommit_lo", 64'(lo), 64'd0);

        // Simultaneous reset and start: start discarded
        cyc(1'b1, 1'b1, 3'b101, 32'h5555_AAAA, '0, 1'b0);
        chk("rst_start_hi", 64'(hi), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 2) == 0);
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            d  = ($urandom_range(0, 1) == 1);
            cyc(r, s, op, a, b, d);
        end
        idle(DC + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
